// File: rtl/nand7420_pkg.sv
// nand7420_pkg: shared state encoding, LFSR mask and NAND reference model for the 7420 tester
package nand7420_pkg;
  typedef enum logic [2:0] {IDLE, SEQ, RAND, DRAIN, DONE} state_t;
  localparam logic [7:0] LFSR_MASK = 8'hB8;
  function automatic logic nand4(input logic [3:0] v);
    return ~&v;
  endfunction
endpackage

// File: rtl/nand7420_lfsr.sv
// nand7420_lfsr: 8-bit right-shift Galois LFSR with synchronous load and advance
module nand7420_lfsr
  import nand7420_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       adv,
  input  logic [7:0] seed,
  output logic [7:0] q
);
  logic [7:0] r_q;
  // load has priority over advance; the register is always loaded before use
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_q <= '0;
    else if (load) r_q <= seed;
    else if (adv) r_q <= r_q[0] ? (r_q >> 1) ^ LFSR_MASK : r_q >> 1;
  assign q = r_q;
endmodule

// File: rtl/nand7420_tester.sv
// nand7420_tester: stimulus driver and checker for a dual 4-input NAND DUT (optional NAND7420_TESTER_INJECT_EN adds inj)
module nand7420_tester
  import nand7420_pkg::*;
#(
  parameter int         SEQ_LEN   = 20,
  parameter int         RAND_LEN  = 200,
  parameter logic [7:0] LFSR_SEED = 8'hA5,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef NAND7420_TESTER_INJECT_EN
  input  logic             inj,
`endif
  output logic             p1a,
  output logic             p1b,
  output logic             p1c,
  output logic             p1d,
  output logic             p2a,
  output logic             p2b,
  output logic             p2c,
  output logic             p2d,
  input  logic             p1y,
  input  logic             p2y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_p1y,
  output logic [CNT_W-1:0] err_p2y,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] first_err
);
  state_t           r_state, w_next;
  logic [3:0]       r_p1, r_p2;
  logic [CNT_W-1:0] r_idx, r_err1, r_err2, r_cnt, r_first, w_idx_inc;
  logic             r_chk_vld, r_seen;
  logic             w_go, w_seq_last, w_rand_last, w_exp1, w_exp2, w_m1, w_m2;
  logic [7:0]       w_lfsr;

  assign w_go        = start && (r_state == IDLE || r_state == DONE);
  assign w_seq_last  = r_state == SEQ && r_idx == CNT_W'(SEQ_LEN - 1);
  assign w_rand_last = r_state == RAND && r_idx == CNT_W'(RAND_LEN - 1);
  assign w_idx_inc   = r_idx + 1'b1;

  nand7420_lfsr u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .load (w_go),
    .adv  (r_state == RAND),
    .seed (LFSR_SEED),
    .q    (w_lfsr)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;

  // next state: start only acts from IDLE or DONE, phases end on their last vector
  always_comb begin
    w_next = r_state;
    if (w_go) w_next = SEQ;
    else if (w_seq_last) w_next = RAND;
    else if (w_rand_last) w_next = DRAIN;
    else if (r_state == DRAIN) w_next = DONE;
  end

  // expected outputs for the vector currently on the pins; inj flips the gate-1 reference
`ifdef NAND7420_TESTER_INJECT_EN
  assign w_exp1 = nand4(r_p1) ^ inj;
`else
  assign w_exp1 = nand4(r_p1);
`endif
  assign w_exp2 = nand4(r_p2);
  assign w_m1   = r_chk_vld && (p1y != w_exp1);
  assign w_m2   = r_chk_vld && (p2y != w_exp2);

  // stimulus registers, check pipeline and saturating result counters
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_p1      <= '0;
      r_p2      <= '0;
      r_idx     <= '0;
      r_chk_vld <= 1'b0;
      r_err1    <= '0;
      r_err2    <= '0;
      r_cnt     <= '0;
      r_first   <= '1;
      r_seen    <= 1'b0;
    end else if (w_go) begin
      r_idx     <= '0;
      r_chk_vld <= 1'b0;
      r_err1    <= '0;
      r_err2    <= '0;
      r_cnt     <= '0;
      r_first   <= '1;
      r_seen    <= 1'b0;
    end else begin
      r_chk_vld <= r_state == SEQ || r_state == RAND;
      if (r_chk_vld) r_cnt <= r_cnt + CNT_W'(r_cnt != '1);
      if (w_m1) r_err1 <= r_err1 + CNT_W'(r_err1 != '1);
      if (w_m2) r_err2 <= r_err2 + CNT_W'(r_err2 != '1);
      if ((w_m1 || w_m2) && !r_seen) begin
        r_first <= r_cnt;
        r_seen  <= 1'b1;
      end
      if (r_state == SEQ) begin
        r_p1  <= r_idx[3:0];
        r_p2  <= w_idx_inc[3:0];
        r_idx <= w_seq_last ? '0 : w_idx_inc;
      end else if (r_state == RAND) begin
        {r_p1, r_p2} <= w_lfsr;
        r_idx        <= w_idx_inc;
      end
    end

  assign {p1a, p1b, p1c, p1d} = r_p1;
  assign {p2a, p2b, p2c, p2d} = r_p2;
  assign busy       = r_state == SEQ || r_state == RAND || r_state == DRAIN;
  assign done       = r_state == DONE;
  assign pass       = done && r_err1 == '0 && r_err2 == '0;
  assign err_p1y    = r_err1;
  assign err_p2y    = r_err2;
  assign sample_cnt = r_cnt;
  assign first_err  = r_first;
endmodule

// File: tb/tb_nand7420_tester.sv
// tb_nand7420_tester: scoreboard bench driving the tester against an ideal or faulty NAND model
module tb_nand7420_tester;
  localparam int N = 220;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stuck = 1'b0, inj_on = 1'b0;
  logic p1a, p1b, p1c, p1d, p2a, p2b, p2c, p2d, p1y, p2y, busy, done, pass;
  logic [15:0] err_p1y, err_p2y, sample_cnt, first_err;
  typedef struct packed {logic ps; logic [15:0] e1, e2, cnt, fe;} exp_t;
  exp_t sb[$];
  logic [7:0] vec[N];
  int checks = 0, fails = 0;

  always #5 clk = ~clk;

  assign p1y = ~&{p1a, p1b, p1c, p1d};
  assign p2y = stuck ? 1'b1 : ~&{p2a, p2b, p2c, p2d};

  nand7420_tester dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef NAND7420_TESTER_INJECT_EN
    .inj(inj_on),
`endif
    .p1a(p1a), .p1b(p1b), .p1c(p1c), .p1d(p1d),
    .p2a(p2a), .p2b(p2b), .p2c(p2c), .p2d(p2d),
    .p1y(p1y), .p2y(p2y), .busy(busy), .done(done), .pass(pass),
    .err_p1y(err_p1y), .err_p2y(err_p2y), .sample_cnt(sample_cnt), .first_err(first_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void build_vec();
    logic [7:0] l;
    for (int k = 0; k < 20; k++) vec[k] = {4'(k), 4'(k + 1)};
    l = 8'hA5;
    for (int r = 0; r < 200; r++) begin
      vec[20 + r] = l;
      l = l[0] ? ({1'b0, l[7:1]} ^ 8'hB8) : {1'b0, l[7:1]};
    end
  endfunction

  task automatic push_expected();
    exp_t e;
    e = '{ps: 1'b1, e1: 16'd0, e2: 16'd0, cnt: 16'(N), fe: 16'hFFFF};
    for (int i = 0; i < N; i++) begin
      logic m1, m2;
      m1 = inj_on;
      m2 = stuck && (vec[i][3:0] == 4'hF);
      e.e1 += 16'(m1);
      e.e2 += 16'(m2);
      if ((m1 || m2) && e.fe == 16'hFFFF) e.fe = 16'(i);
    end
    e.ps = (e.e1 == 0) && (e.e2 == 0);
    sb.push_back(e);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_pins"}, {p1a, p1b, p1c, p1d, p2a, p2b, p2c, p2d}, 0);
    chk({tag, "_flags"}, {busy, done, pass}, 0);
    chk({tag, "_err1"}, err_p1y, 0);
    chk({tag, "_err2"}, err_p2y, 0);
    chk({tag, "_cnt"}, sample_cnt, 0);
    chk({tag, "_first"}, first_err, 32'hFFFF);
  endtask

  task automatic run(input string tag, input bit chkvec, input int busy_start_at, input int abort_at);
    int n;
    exp_t e;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 1;
    while (!done && n < 300) begin
      @(posedge clk);
      #1 start = 1'b0;
      n++;
      if (chkvec && n >= 2 && n <= N + 1)
        chk($sformatf("%s_vec%0d", tag, n - 2), {p1a, p1b, p1c, p1d, p2a, p2b, p2c, p2d}, vec[n - 2]);
      if (n == 3) chk({tag, "_busy"}, busy, 1);
      if (n == busy_start_at) start = 1'b1;
      if (n == abort_at) begin
        rst_n = 1'b0;
        #1 check_reset({tag, "_abort"});
        @(negedge clk) rst_n = 1'b1;
        return;
      end
    end
    chk({tag, "_latency"}, n, N + 2);
    chk({tag, "_sb_nonempty"}, sb.size() > 0, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_pass"}, pass, e.ps);
      chk({tag, "_err1"}, err_p1y, e.e1);
      chk({tag, "_err2"}, err_p2y, e.e2);
      chk({tag, "_cnt"}, sample_cnt, e.cnt);
      chk({tag, "_first"}, first_err, e.fe);
    end
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_done_held"}, {done, busy}, 2'b10);
    chk({tag, "_pins_hold"}, {p1a, p1b, p1c, p1d, p2a, p2b, p2c, p2d}, vec[N - 1]);
  endtask

  initial begin
    build_vec();
    #12 check_reset("reset");
    @(negedge clk) rst_n = 1'b1;
    push_expected();
    run("golden", 1'b1, 50, 0);
    stuck = 1'b1;
    push_expected();
    run("stuck", 1'b0, 0, 0);
    stuck = 1'b0;
    run("abort", 1'b0, 0, 52);
    push_expected();
    run("after_rst", 1'b1, 0, 0);
`ifdef NAND7420_TESTER_INJECT_EN
    inj_on = 1'b1;
    push_expected();
    run("inj", 1'b0, 0, 0);
    inj_on = 1'b0;
`endif
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
